tap_frame_serializer: RTL and testbench

//   Downstream consumer of the 3-tap 8-bit counter pipeline. Periodically samples
//   all taps as one frame into a small frame FIFO, then streams each frame out

---
 rtl/tap_frame_serializer.sv | 262 ++++++++++++++++++++++++++
 tb/tb_tap_frame_serializer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tap_frame_serializer.sv
// tap_frame_serializer
// Periodically captures all taps of the counter pipeline as one frame into a
// small frame FIFO, then streams each frame out one tap per byte over a
// valid/ready interface for the trace/log path.
//
// Optional feature: define TAP_CHECK_EN to build the tap-relation checker
// (tap[k] == tap[k-1] - 1 mod 2^DATA_W). Without it tap_err is tied low.
//
// Ports
//   clk          in   clock, all logic on rising edge
//   rst          in   asynchronous reset, active high
//   tap_in       in   NUM_TAPS*DATA_W, tap k at [k*DATA_W +: DATA_W]
//   sample_en    in   enables the sample divider
//   out_data     out  current byte (tap value)
//   out_tap_idx  out  tap index of out_data
//   out_valid    out  byte valid
//   out_ready    in   sink accepts byte
//   out_last     out  byte is the last tap of its frame
//   overflow     out  sticky: a frame was dropped because the FIFO was full
//   tap_err      out  sticky: tap relation violated (TAP_CHECK_EN only)

module tap_frame_serializer #(
    parameter int DATA_W     = 8,
    parameter int NUM_TAPS   = 3,
    parameter int DEPTH      = 4,
    parameter int SAMPLE_DIV = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_TAPS*DATA_W-1:0] tap_in,
    input  logic                       sample_en,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(NUM_TAPS)-1:0] out_tap_idx,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       overflow,
    output logic                       tap_err
);

    localparam int FRAME_W = NUM_TAPS * DATA_W;
    localparam int IDX_W   = $clog2(NUM_TAPS);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int DIV_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_TAPS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    // ------------------------------------------------------------------
    // Sample divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q, div_d;
    logic             strobe;

    always_comb begin
        div_d  = div_q;
        strobe = 1'b0;
        if (sample_en) begin
            if (div_q == DIV_MAX) begin
                strobe = 1'b1;
                div_d  = '0;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FIFO
    // ------------------------------------------------------------------
    logic [FRAME_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic               full;
    logic               empty;
    logic               hs;
    logic               pop;
    logic               push;
    logic [FRAME_W-1:0] head;
    logic [FRAME_W-1:0] next_head;

    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    state_t             state_q, state_d;

    assign full  = (cnt_q == CNT_FULL);
    assign empty = (cnt_q == '0);
    assign hs    = valid_q & out_ready;
    assign pop   = hs & last_q;
    // A pop on the same edge frees the slot the new frame needs.
    assign push  = strobe & (~full | pop);

    assign head      = mem_q[rd_ptr_q];
    assign next_head = mem_q[rd_ptr_q + PTR_W'(1)];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q | (strobe & full & ~pop);
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Frame storage carries no reset; occupancy is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tap_in;
        end
    end

    function automatic logic [DATA_W-1:0] tap_sel(
        input logic [FRAME_W-1:0] f,
        input logic [IDX_W-1:0]   i
    );
        logic [DATA_W-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            if (i == IDX_W'(k)) begin
                r = f[k*DATA_W +: DATA_W];
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Serializer FSM (registered outputs)
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        data_d  = data_q;
        idx_d   = idx_q;
        last_d  = last_q;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    state_d = S_SEND;
                    valid_d = 1'b1;
                    data_d  = tap_sel(head, '0);
                    idx_d   = '0;
                    last_d  = 1'b0;
                end
            end
            S_SEND: begin
                if (hs) begin
                    if (last_q) begin
                        idx_d  = '0;
                        last_d = 1'b0;
                        // Another stored frame follows without a bubble.
                        if (cnt_q > CNT_ONE) begin
                            data_d = tap_sel(next_head, '0);
                        end else begin
                            state_d = S_IDLE;
                            valid_d = 1'b0;
                            data_d  = '0;
                        end
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        data_d = tap_sel(head, idx_q + IDX_W'(1));
                        last_d = ((idx_q + IDX_W'(1)) == IDX_LAST);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            state_q  <= S_IDLE;
            valid_q  <= 1'b0;
            data_q   <= '0;
            idx_q    <= '0;
            last_q   <= 1'b0;
        end else begin
            div_q    <= div_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_data    = data_q;
    assign out_tap_idx = idx_q;
    assign out_last    = last_q;
    assign overflow    = ovf_q;

    // ------------------------------------------------------------------
    // Optional tap-relation checker
    // ------------------------------------------------------------------
`ifdef TAP_CHECK_EN
    logic armed_q, armed_d;
    logic err_q, err_d;
    logic consistent;

    always_comb begin
        consistent = 1'b1;
        for (int k = 1; k < NUM_TAPS; k++) begin
            if (tap_in[k*DATA_W +: DATA_W] !=
                (tap_in[(k-1)*DATA_W +: DATA_W] - DATA_W'(1))) begin
                consistent = 1'b0;
            end
        end
    end

    // Every sampled frame is checked, including ones the FIFO drops.
    always_comb begin
        armed_d = armed_q | (strobe & consistent);
        err_d   = err_q | (strobe & armed_q & ~consistent);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            armed_q <= armed_d;
            err_q   <= err_d;
        end
    end

    assign tap_err = err_q;
`else
    assign tap_err = 1'b0;
`endif

endmodule

// File: tb/tb_tap_frame_serializer.sv
// tb_tap_frame_serializer
// Directed bench for tap_frame_serializer (SAMPLE_DIV=4, DEPTH=4, 3 taps).

module tb_tap_frame_serializer;

    logic        clk;
    logic        rst;
    logic [23:0] tap_in;
    logic        sample_en;
    logic [7:0]  out_data;
    logic [1:0]  out_tap_idx;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        overflow;
    logic        tap_err;

    int passed = 0;
    int failed = 0;
    int total  = 0;

`ifdef TAP_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    tap_frame_serializer #(
        .DATA_W    (8),
        .NUM_TAPS  (3),
        .DEPTH     (4),
        .SAMPLE_DIV(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tap_in     (tap_in),
        .sample_en  (sample_en),
        .out_data   (out_data),
        .out_tap_idx(out_tap_idx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .overflow   (overflow),
        .tap_err    (tap_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] fr(input logic [7:0] t0,
                                       input logic [7:0] t1,
                                       input logic [7:0] t2);
        return {t2, t1, t0};
    endfunction

    // Divider sits at 0: four enabled edges give exactly one capture,
    // on the fourth edge. Returns at the negedge right after it.
    task automatic cap(input logic [23:0] f);
        @(negedge clk);
        tap_in    = f;
        sample_en = 1'b1;
        repeat (4) @(negedge clk);
        sample_en = 1'b0;
    endtask

    // Wait (bounded) for a byte, check it, let the next edge accept it.
    task automatic get_byte(input string tag, input logic [7:0] d,
                            input logic [1:0] i, input logic l);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_data"}, {24'd0, out_data}, {24'd0, d});
        chk({tag, "_idx"}, {30'd0, out_tap_idx}, {30'd0, i});
        chk({tag, "_last"}, {31'd0, out_last}, {31'd0, l});
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] b;

        rst       = 1'b1;
        tap_in    = '0;
        sample_en = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_idx", {30'd0, out_tap_idx}, 32'd0);
        chk("rst_last", {31'd0, out_last}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_err", {31'd0, tap_err}, 32'd0);
        rst = 1'b0;

        // T1: basic frames and capture-to-valid latency
        out_ready = 1'b1;
        cap(fr(8'd0, 8'd1, 8'd2));
        chk("t1_lat0", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("t1_lat1", {31'd0, out_valid}, 32'd1);
        get_byte("t1_a0", 8'd0, 2'd0, 1'b0);
        get_byte("t1_a1", 8'd1, 2'd1, 1'b0);
        get_byte("t1_a2", 8'd2, 2'd2, 1'b1);
        cap(fr(8'd4, 8'd5, 8'd6));
        get_byte("t1_b0", 8'd4, 2'd0, 1'b0);
        get_byte("t1_b1", 8'd5, 2'd1, 1'b0);
        get_byte("t1_b2", 8'd6, 2'd2, 1'b1);

        // T2: backpressure mid-frame
        cap(fr(8'd10, 8'd11, 8'd12));
        get_byte("t2_0", 8'd10, 2'd0, 1'b0);
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk("t2_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t2_hold_data", {24'd0, out_data}, 32'd11);
            chk("t2_hold_idx", {30'd0, out_tap_idx}, 32'd1);
            chk("t2_hold_last", {31'd0, out_last}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        get_byte("t2_1", 8'd11, 2'd1, 1'b0);
        get_byte("t2_2", 8'd12, 2'd2, 1'b1);
        chk("t2_nodup", {31'd0, out_valid}, 32'd0);

        // T3: overflow on fifth capture, first four frames survive
        out_ready = 1'b0;
        for (int f = 0; f < 5; f++) begin
            b = 8'(32 + 16 * f);
            cap(fr(b, b + 8'd1, b + 8'd2));
            if (f == 3) chk("t3_ovf_before", {31'd0, overflow}, 32'd0);
        end
        chk("t3_ovf_after", {31'd0, overflow}, 32'd1);
        out_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            b = 8'(32 + 16 * f);
            get_byte("t3_t0", b, 2'd0, 1'b0);
            get_byte("t3_t1", b + 8'd1, 2'd1, 1'b0);
            get_byte("t3_t2", b + 8'd2, 2'd2, 1'b1);
        end
        repeat (3) @(negedge clk);
        chk("t3_drained", {31'd0, out_valid}, 32'd0);

        // T5: reset in the middle of a frame
        cap(fr(8'h70, 8'h71, 8'h72));
        get_byte("t5_pre", 8'h70, 2'd0, 1'b0);
        chk("t5_mid_idx", {30'd0, out_tap_idx}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_rst_data", {24'd0, out_data}, 32'd0);
        chk("t5_rst_idx", {30'd0, out_tap_idx}, 32'd0);
        chk("t5_rst_last", {31'd0, out_last}, 32'd0);
        chk("t5_rst_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_empty", {31'd0, out_valid}, 32'd0);
        cap(fr(8'h80, 8'h81, 8'h82));
        get_byte("t5_n0", 8'h80, 2'd0, 1'b0);
        get_byte("t5_n1", 8'h81, 2'd1, 1'b0);
        get_byte("t5_n2", 8'h82, 2'd2, 1'b1);

        // T4: capture into a full FIFO on the last-byte handshake edge
        out_ready = 1'b0;
        for (int f = 0; f < 4; f++) begin
            b = 8'(144 + 16 * f);
            cap(fr(b, b + 8'd1, b + 8'd2));
        end
        chk("t4_full_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        tap_in    = fr(8'hD0, 8'hD1, 8'hD2);
        sample_en = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        chk("t4_h0", {24'd0, out_data}, 32'h90);
        @(negedge clk);
        chk("t4_h1", {24'd0, out_data}, 32'h91);
        @(negedge clk);
        chk("t4_h2", {24'd0, out_data}, 32'h92);
        chk("t4_h2_last", {31'd0, out_last}, 32'd1);
        @(negedge clk);
        sample_en = 1'b0;
        chk("t4_ovf_same_edge", {31'd0, overflow}, 32'd0);
        chk("t4_b2b_valid", {31'd0, out_valid}, 32'd1);
        for (int f = 1; f < 5; f++) begin
            b = 8'(144 + 16 * f);
            get_byte("t4_t0", b, 2'd0, 1'b0);
            get_byte("t4_t1", b + 8'd1, 2'd1, 1'b0);
            get_byte("t4_t2", b + 8'd2, 2'd2, 1'b1);
        end
        chk("t4_drained", {31'd0, out_valid}, 32'd0);
        chk("t4_ovf_end", {31'd0, overflow}, 32'd0);

        // T6: tap relation checker
        chk("t6_err_pre", {31'd0, tap_err}, 32'd0);
        cap(fr(8'd3, 8'd2, 8'd1));
        get_byte("t6_a0", 8'd3, 2'd0, 1'b0);
        get_byte("t6_a1", 8'd2, 2'd1, 1'b0);
        get_byte("t6_a2", 8'd1, 2'd2, 1'b1);
        chk("t6_err_armed", {31'd0, tap_err}, 32'd0);
        cap(fr(8'd9, 8'd7, 8'd6));
        chk("t6_err_set", {31'd0, tap_err}, {31'd0, EXP_ERR});
        get_byte("t6_b0", 8'd9, 2'd0, 1'b0);
        get_byte("t6_b1", 8'd7, 2'd1, 1'b0);
        get_byte("t6_b2", 8'd6, 2'd2, 1'b1);
        chk("t6_err_sticky", {31'd0, tap_err}, {31'd0, EXP_ERR});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
